fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of the 16-bit PC register. It reads the current PC and issues a single-outstanding request to instruction memory. Returned words are buffered with their PC in a small FIFO that feeds decode through a valid/ready handshake. It drives the PC register's 2-bit `nop` control: 2'b01 holds the PC, 2'b00 lets it load its next-PC input.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests, PC/word FIFO toward decode, PC hold/advance control.
// Optional FETCH_PERF_EN adds saturating fetch and decode-stall counters.
module fetch_unit #(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        pc_in,
  output logic [1:0]         pc_nop,
  input  logic               flush,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [15:0]        id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetches,
  output logic [15:0]        perf_stalls
`endif
);

  // state | meaning
  // IDLE  | no request outstanding; issue one if FIFO has room and no redirect
  // REQ   | request outstanding; returned word is kept
  // DRAIN | request outstanding after a flush; returned word is discarded
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t               state;
  logic [INSTR_W-1:0]   instr_mem [DEPTH];
  logic [15:0]          pc_mem    [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 push;
  logic                 pop;

  assign full     = (count == CW'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = (state == REQ) && imem_ack && !flush;
  assign pop      = id_valid && id_ready;
  assign id_instr = instr_mem[rd_ptr];
  assign id_pc    = pc_mem[rd_ptr];

  // PC advances once per kept word or per redirect.
  always_comb begin
    pc_nop = 2'b01;
    if (flush || push) pc_nop = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (!flush && !full) begin
            imem_addr <= pc_in;
            imem_req  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]    <= imem_addr;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetches <= 16'h0000;
      perf_stalls  <= 16'h0000;
    end else begin
      if (push && perf_fetches != 16'hFFFF) perf_fetches <= perf_fetches + 16'd1;
      if (id_valid && !id_ready && perf_stalls != 16'hFFFF) perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected {pc, word} per kept fetch,
// a negedge monitor pops and compares on every decode handshake.
module tb_fetch_unit;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [15:0]        pc_in = 16'h0000;
  logic [1:0]         pc_nop;
  logic               flush = 1'b0;
  logic               imem_req;
  logic [15:0]        imem_addr;
  logic               imem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               id_valid;
  logic               id_ready = 1'b1;
  logic [INSTR_W-1:0] id_instr;
  logic [15:0]        id_pc;
`ifdef FETCH_PERF_EN
  logic [15:0]        perf_fetches;
  logic [15:0]        perf_stalls;
`endif

  fetch_unit #(.INSTR_W(INSTR_W), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_nop(pc_nop), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetches(perf_fetches), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]        pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [INSTR_W-1:0] word(input logic [15:0] pc);
    return {~pc, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IDLE cycle that issues a request for pc.
  task automatic issue(input logic [15:0] pc);
    pc_in    = pc;
    flush    = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_nop", 32'(pc_nop), 32'd1);
    step();
  endtask

  // REQ cycles: delay wait cycles, then an ack returning word(pc), which is kept.
  task automatic serve(input logic [15:0] pc, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'(pc));
      chk("wait_nop", 32'(pc_nop), 32'd1);
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = word(pc);
    sb.push_back({pc, word(pc)});
    @(negedge clk);
    chk("ack_req", 32'(imem_req), 32'd1);
    chk("ack_addr", 32'(imem_addr), 32'(pc));
    chk("ack_nop", 32'(pc_nop), 32'd0);
    step();
    imem_ack = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] pc, input int delay);
    issue(pc);
    serve(pc, delay);
  endtask

  always @(negedge clk) begin
    if (!reset && !flush && id_valid && id_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL id_unexpected: got pc %h instr %h, expected no valid output", id_pc, id_instr);
      end else begin
        mon_e = sb.pop_front();
        if (id_pc !== mon_e.pc || id_instr !== mon_e.instr) begin
          n_bad++;
          $display("FAIL id_data: got pc %h instr %h expected pc %h instr %h",
                   id_pc, id_instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    step();
    step();
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", 32'(id_instr), 32'd0);
    chk("rst_pc", 32'(id_pc), 32'd0);
    chk("rst_nop", 32'(pc_nop), 32'd1);
`ifdef FETCH_PERF_EN
    chk("rst_perf", 32'(perf_fetches), 32'd0);
`endif
    step();
    reset = 1'b0;

    // Zero-wait fetch, data visible the next cycle
    fetch(16'h0010, 0);
    pc_in = 16'h0014;
    @(negedge clk);
    chk("zw_valid", 32'(id_valid), 32'd1);
    chk("zw_pc", 32'(id_pc), 32'h0010);
    chk("zw_instr", 32'(id_instr), 32'(word(16'h0010)));
    step();

    // Ack delayed 3 cycles
    serve(16'h0014, 3);

    // Fill the FIFO with decode stalled
    issue(16'h0100);
    id_ready = 1'b0;
    serve(16'h0100, 0);
    fetch(16'h0104, 0);
    fetch(16'h0108, 0);
    fetch(16'h010C, 0);
    pc_in = 16'h0110;
    repeat (3) begin
      @(negedge clk);
      chk("full_req", 32'(imem_req), 32'd0);
      chk("full_valid", 32'(id_valid), 32'd1);
      chk("full_nop", 32'(pc_nop), 32'd1);
      step();
    end
    id_ready = 1'b1;
    @(negedge clk);
    chk("pop_req", 32'(imem_req), 32'd0);
    step();
    id_ready = 1'b0;
    issue(16'h0110);
    serve(16'h0110, 0);
    repeat (2) begin
      @(negedge clk);
      chk("refull_req", 32'(imem_req), 32'd0);
      step();
    end

    // Drain; FSM picks up a new request at 0x0200 meanwhile
    pc_in = 16'h0200;
    id_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() > 0; n++) begin
      @(negedge clk);
      step();
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    id_ready = 1'b0;
    serve(16'h0200, 0);

    // Flush in REQ with a non-empty FIFO, ack 2 cycles later
    pc_in = 16'h0204;
    @(negedge clk);
    chk("pre_flush_valid", 32'(id_valid), 32'd1);
    step();
    flush = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("flush_nop", 32'(pc_nop), 32'd0);
    chk("flush_req", 32'(imem_req), 32'd1);
    chk("flush_addr", 32'(imem_addr), 32'h0204);
    step();
    flush = 1'b0;
    pc_in = 16'h0300;
    @(negedge clk);
    chk("drain_valid", 32'(id_valid), 32'd0);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_nop", 32'(pc_nop), 32'd1);
    step();
    imem_ack   = 1'b1;
    imem_rdata = word(16'h0204);
    @(negedge clk);
    chk("drain_ack_nop", 32'(pc_nop), 32'd1);
    step();
    imem_ack = 1'b0;
    id_ready = 1'b1;
    fetch(16'h0300, 1);

    // Flush with ack in the same cycle, then flush in IDLE
    issue(16'h0500);
    flush      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = word(16'h0500);
    @(negedge clk);
    chk("fa_nop", 32'(pc_nop), 32'd0);
    chk("fa_req", 32'(imem_req), 32'd1);
    step();
    imem_ack = 1'b0;
    pc_in    = 16'h0600;
    @(negedge clk);
    chk("fi_valid", 32'(id_valid), 32'd0);
    chk("fi_req", 32'(imem_req), 32'd0);
    chk("fi_nop", 32'(pc_nop), 32'd0);
    step();
    flush = 1'b0;
    fetch(16'h0700, 0);

    // Reset while a request is outstanding; late ack ignored
    issue(16'h0800);
    reset = 1'b1;
    @(negedge clk);
    chk("prerst_req", 32'(imem_req), 32'd1);
    step();
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rst2_req", 32'(imem_req), 32'd0);
    chk("rst2_addr", 32'(imem_addr), 32'd0);
    chk("rst2_valid", 32'(id_valid), 32'd0);
    chk("rst2_pc", 32'(id_pc), 32'd0);
    chk("rst2_instr", 32'(id_instr), 32'd0);
    chk("rst2_nop", 32'(pc_nop), 32'd1);
`ifdef FETCH_PERF_EN
    chk("rst2_perf", 32'(perf_fetches), 32'd0);
`endif
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_valid", 32'(id_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
